// File: rtl/trace_capture_ctrl_if.sv
// Output stream of the trace capture controller: FIFO head to host-side consumer.
// Build macro TRACE_TIMESTAMP_EN adds the m_timestamp field.
interface trace_capture_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32
`ifdef TRACE_TIMESTAMP_EN
  , parameter int unsigned CNT_WIDTH = 32
`endif
);
  logic                   m_valid;
  logic                   m_ready;
  logic [PC_WIDTH-1:0]    m_pc;
  logic [INSTR_WIDTH-1:0] m_instr;
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0]   m_timestamp;

  modport master (output m_valid, m_pc, m_instr, m_timestamp, input m_ready);
  modport slave  (input m_valid, m_pc, m_instr, m_timestamp, output m_ready);
`else
  modport master (output m_valid, m_pc, m_instr, input m_ready);
  modport slave  (input m_valid, m_pc, m_instr, output m_ready);
`endif
endinterface

// File: rtl/trace_capture_ctrl.sv
// Commit-trace capture: filter gating, FIFO buffering, start/stop/drain control and counters.
// Build macro TRACE_TIMESTAMP_EN stores a capture-cycle timestamp with each entry.
module trace_capture_ctrl #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   cfg_filter_bypass,
  input  logic                   tr_valid,
  input  logic [PC_WIDTH-1:0]    tr_pc,
  input  logic [INSTR_WIDTH-1:0] tr_instr,
  input  logic                   drop_instr,
  trace_capture_ctrl_if.master   m,
  output logic                   busy,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   kept_cnt,
  output logic [CNT_WIDTH-1:0]   dropped_cnt,
  output logic [CNT_WIDTH-1:0]   overflow_cnt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [AW:0]            r_wr_ptr, r_rd_ptr;
  logic [PC_WIDTH-1:0]    r_pc_mem    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
  logic w_empty, w_full, w_valid, w_pop, w_push, w_lost, w_keep, w_discard, w_start, w_run;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // Wrap bit distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_run     = (r_state == S_RUN);
  assign w_keep    = w_run & tr_valid & (cfg_filter_bypass | ~drop_instr);
  assign w_discard = w_run & tr_valid & ~(cfg_filter_bypass | ~drop_instr);
  assign w_valid   = ~w_empty & (r_state != S_IDLE);
  assign w_pop     = w_valid & m.m_ready;
  assign w_push    = w_keep & (~w_full | w_pop);
  assign w_lost    = w_keep & w_full & ~w_pop;
  assign w_start   = (r_state == S_IDLE) & cmd_start & ~cmd_stop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE:  if (cmd_start && !cmd_stop) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cmd_stop) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      overflow     <= 1'b0;
      kept_cnt     <= '0;
      dropped_cnt  <= '0;
      overflow_cnt <= '0;
    end else begin
      if (w_push)    r_wr_ptr     <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr     <= r_rd_ptr + PTR_ONE;
      if (w_push)    kept_cnt     <= sat_inc(kept_cnt);
      if (w_discard) dropped_cnt  <= sat_inc(dropped_cnt);
      if (w_lost) begin
        overflow_cnt <= sat_inc(overflow_cnt);
        overflow     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr[AW-1:0]]    <= tr_pc;
      r_instr_mem[r_wr_ptr[AW-1:0]] <= tr_instr;
    end
  end

  // Head is gated so outputs read zero while empty, including straight after reset.
  assign m.m_valid = w_valid;
  assign m.m_pc    = w_valid ? r_pc_mem[r_rd_ptr[AW-1:0]]    : '0;
  assign m.m_instr = w_valid ? r_instr_mem[r_rd_ptr[AW-1:0]] : '0;

`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] r_ts;
  logic [CNT_WIDTH-1:0] r_ts_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || w_start) r_ts <= '0;
    else                   r_ts <= r_ts + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ts_mem[r_wr_ptr[AW-1:0]] <= r_ts;
  end

  assign m.m_timestamp = w_valid ? r_ts_mem[r_rd_ptr[AW-1:0]] : '0;
`endif
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed self-checking bench for trace_capture_ctrl (default FIFO_DEPTH=8).
module tb_trace_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, cmd_start, cmd_stop, cfg_filter_bypass;
  logic        tr_valid, drop_instr;
  logic [63:0] tr_pc;
  logic [31:0] tr_instr;
  logic        busy, overflow;
  logic [31:0] kept_cnt, dropped_cnt, overflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  trace_capture_ctrl_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) m_if ();

  trace_capture_ctrl #(
    .PC_WIDTH(64), .INSTR_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_filter_bypass(cfg_filter_bypass), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .drop_instr(drop_instr), .m(m_if), .busy(busy),
    .overflow(overflow), .kept_cnt(kept_cnt), .dropped_cnt(dropped_cnt),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qpc(input int i);
    return 64'h8000_0000_0000_1000 + 64'(i) * 64'd4;
  endfunction

  function automatic logic [31:0] qin(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic item(input logic [63:0] pc, input logic [31:0] ins, input logic drop);
    tr_valid = 1'b1; tr_pc = pc; tr_instr = ins; drop_instr = drop;
  endtask

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_filter_bypass = 1'b0;
    tr_valid = 1'b0; tr_pc = '0; tr_instr = '0; drop_instr = 1'b0; m_if.m_ready = 1'b0;
    tick(); tick();
    chk("rst_m_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst_m_pc", m_if.m_pc, 64'd0);
    chk("rst_m_instr", 64'(m_if.m_instr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_kept", 64'(kept_cnt), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt), 64'd0);
    chk("rst_ovf_cnt", 64'(overflow_cnt), 64'd0);
    rst_n = 1'b1; tick();

    // filter: keep, drop, keep, drop with consumer always ready
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    m_if.m_ready = 1'b1;
    item(qpc(100), qin(100), 1'b0); tick();
    chk("f0_valid", 64'(m_if.m_valid), 64'd1);
    chk("f0_pc", m_if.m_pc, qpc(100));
    chk("f0_instr", 64'(m_if.m_instr), 64'(qin(100)));
    item(qpc(101), qin(101), 1'b1); tick();
    chk("f1_valid", 64'(m_if.m_valid), 64'd0);
    item(qpc(102), qin(102), 1'b0); tick();
    chk("f2_valid", 64'(m_if.m_valid), 64'd1);
    chk("f2_pc", m_if.m_pc, qpc(102));
    item(qpc(103), qin(103), 1'b1); tick();
    tr_valid = 1'b0;
    chk("f3_valid", 64'(m_if.m_valid), 64'd0);
    chk("f_kept", 64'(kept_cnt), 64'd2);
    chk("f_dropped", 64'(dropped_cnt), 64'd2);

    // stop with empty FIFO, counters hold in IDLE, restart clears them
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0; tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_kept_hold", 64'(kept_cnt), 64'd2);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("restart_kept", 64'(kept_cnt), 64'd0);
    chk("restart_dropped", 64'(dropped_cnt), 64'd0);

    // stalled consumer: 10 kept items into 8 entries
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      item(qpc(i), qin(i), 1'b0); tick();
      chk("stall_pc", m_if.m_pc, qpc(0));
    end
    chk("ovf_kept", 64'(kept_cnt), 64'd8);
    chk("ovf_cnt", 64'(overflow_cnt), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_valid", 64'(m_if.m_valid), 64'd1);

    // full + pop + push in one cycle is accepted
    m_if.m_ready = 1'b1;
    item(qpc(10), qin(10), 1'b0); tick();
    chk("fullpush_kept", 64'(kept_cnt), 64'd9);
    chk("fullpush_ovf_cnt", 64'(overflow_cnt), 64'd2);
    chk("fullpush_head", m_if.m_pc, qpc(1));
    m_if.m_ready = 1'b0;
    item(qpc(11), qin(11), 1'b0); tick();
    chk("still_full_ovf_cnt", 64'(overflow_cnt), 64'd3);
    chk("still_full_kept", 64'(kept_cnt), 64'd9);
    tr_valid = 1'b0; m_if.m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("drain_valid", 64'(m_if.m_valid), 64'd1);
      chk("drain_pc", m_if.m_pc, (j < 7) ? qpc(j + 1) : qpc(10));
      chk("drain_instr", 64'(m_if.m_instr), 64'((j < 7) ? qin(j + 1) : qin(10)));
      tick();
    end
    chk("drained_valid", 64'(m_if.m_valid), 64'd0);

    // stop with 3 buffered, consumer ready pattern 1,0,1,0,1
    m_if.m_ready = 1'b0;
    item(qpc(200), qin(200), 1'b0); tick();
    item(qpc(201), qin(201), 1'b0); tick();
    item(qpc(202), qin(202), 1'b0); cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    item(qpc(203), qin(203), 1'b0);
    m_if.m_ready = 1'b1;
    chk("d0_pc", m_if.m_pc, qpc(200));
    chk("d0_busy", 64'(busy), 64'd1);
    tick(); m_if.m_ready = 1'b0;
    chk("d1_pc", m_if.m_pc, qpc(201));
    chk("d1_kept_no_capture", 64'(kept_cnt), 64'd12);
    chk("d1_overflow_sticky", 64'(overflow), 64'd1);
    tick(); m_if.m_ready = 1'b1;
    chk("d2_pc_stable", m_if.m_pc, qpc(201));
    tick(); m_if.m_ready = 1'b0;
    chk("d3_pc", m_if.m_pc, qpc(202));
    tick(); m_if.m_ready = 1'b1;
    chk("d4_pc", m_if.m_pc, qpc(202));
    chk("d4_busy", 64'(busy), 64'd1);
    tick();
    tr_valid = 1'b0;
    chk("d5_valid", 64'(m_if.m_valid), 64'd0);
    tick();
    chk("d6_busy", 64'(busy), 64'd0);
    chk("d6_kept", 64'(kept_cnt), 64'd12);

    // start and stop together in IDLE: no effect
    cmd_start = 1'b1; cmd_stop = 1'b1; tick(); cmd_start = 1'b0; cmd_stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_kept", 64'(kept_cnt), 64'd12);

    // reset while draining
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("s2_overflow_clr", 64'(overflow), 64'd0);
    chk("s2_kept_clr", 64'(kept_cnt), 64'd0);
    m_if.m_ready = 1'b0;
    item(qpc(300), qin(300), 1'b0); tick();
    item(qpc(301), qin(301), 1'b0); tick();
    tr_valid = 1'b0; cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_pc", m_if.m_pc, qpc(300));
    chk("rd_kept", 64'(kept_cnt), 64'd2);
    rst_n = 1'b0; tick();
    chk("rd_rst_valid", 64'(m_if.m_valid), 64'd0);
    chk("rd_rst_pc", m_if.m_pc, 64'd0);
    chk("rd_rst_busy", 64'(busy), 64'd0);
    chk("rd_rst_kept", 64'(kept_cnt), 64'd0);
    rst_n = 1'b1; tick();

    // bypass: all drop_instr=1 items are kept
    cfg_filter_bypass = 1'b1; m_if.m_ready = 1'b1;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      item(qpc(400 + i), qin(400 + i), 1'b1); tick();
      chk("byp_valid", 64'(m_if.m_valid), 64'd1);
      chk("byp_pc", m_if.m_pc, qpc(400 + i));
`ifdef TRACE_TIMESTAMP_EN
      chk("byp_ts", 64'(m_if.m_timestamp), 64'(i));
`endif
    end
    tr_valid = 1'b0;
    chk("byp_kept", 64'(kept_cnt), 64'd5);
    chk("byp_dropped", 64'(dropped_cnt), 64'd0);
    tick();
    chk("byp_empty", 64'(m_if.m_valid), 64'd0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0; tick();
    chk("byp_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Sequences the capture of the committed-instruction trace: gates the per-instruction keep/drop decision from the branch/jump filter, buffers kept items in a small FIFO and streams them to the host-side consumer over a valid/ready handshake. It implements start/stop/drain control, overflow accounting and kept/dropped counters. It sits between the core's commit trace port, the filter output and the continuous-monitoring transport.

Parameters:
PC_WIDTH, 64, width of program-counter field
INSTR_WIDTH, 32, width of instruction field
FIFO_DEPTH, 8, buffer entries; power of two, >= 2
CNT_WIDTH, 32, width of kept/dropped/overflow counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
cmd_start  in  1  pulse: begin capture
cmd_stop  in  1  pulse: stop capture, then drain
cfg_filter_bypass  in  1  1 = ignore drop_instr, keep every valid instruction
tr_valid  in  1  commit trace item valid this cycle
tr_pc  in  PC_WIDTH  committed PC
tr_instr  in  INSTR_WIDTH  committed instruction
drop_instr  in  1  filter decision for tr_instr (combinational, same cycle)
m_valid  out  1  output item valid
m_ready  in  1  consumer ready
m_pc  out  PC_WIDTH  output PC
m_instr  out  INSTR_WIDTH  output instruction
busy  out  1  state != IDLE
overflow  out  1  sticky: a kept item was lost since last start
kept_cnt  out  CNT_WIDTH  items written to FIFO
dropped_cnt  out  CNT_WIDTH  valid items discarded by the filter
overflow_cnt  out  CNT_WIDTH  kept items lost because FIFO was full

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, FIFO empty, m_valid=0, m_pc=0, m_instr=0, busy=0, overflow=0, all counters 0. Reset mid-capture or mid-drain discards FIFO contents.
- States: IDLE, RUN, DRAIN.
  IDLE -> RUN on cmd_start (clears counters, overflow and FIFO in the same edge).
  RUN -> DRAIN on cmd_stop.
  DRAIN -> IDLE when FIFO is empty and no pop is pending.
  cmd_start and cmd_stop in the same cycle: stop wins (IDLE stays IDLE; RUN -> DRAIN).
  cmd_start in RUN or DRAIN is ignored.
- Capture (RUN only): keep = tr_valid & (cfg_filter_bypass | ~drop_instr); discard = tr_valid & ~keep.
  keep with FIFO not full, or full with a pop in the same cycle: write {tr_pc, tr_instr}; kept_cnt+1.
  keep with FIFO full and no pop: item lost; overflow_cnt+1; overflow<=1.
  discard: dropped_cnt+1.
  The cmd_stop cycle itself still captures.
- Output: FIFO head drives m_pc/m_instr; m_valid = FIFO not empty (RUN or DRAIN). Pop on m_valid & m_ready. m_pc/m_instr must hold stable while m_valid & ~m_ready.
- Latency: item captured at edge N appears with m_valid=1 after edge N (visible in cycle N+1); no combinational path from tr_* to m_*.
- Throughput: one write and one pop per cycle, sustained.
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit; full/empty derived from the wrap bit. Wrap-around must be seamless.
- Counters saturate at all-ones; no wrap.
- In IDLE, tr_* is ignored and counters hold their last values for readout.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined: adds a free-running CNT_WIDTH cycle counter, cleared on cmd_start. Each FIFO entry stores the counter value at capture. Adds output port m_timestamp [CNT_WIDTH], which follows the m_pc stability rules and resets to 0.
- Undefined: no counter, no extra storage, port absent.

Test Plan:
- Reset, then cmd_start, then 4 valid items with drop_instr=0,1,0,1 and m_ready=1 -> exactly 2 items out, in order, each 1 cycle after capture; kept_cnt=2, dropped_cnt=2.
- m_ready=0, FIFO_DEPTH=8, 10 kept items -> 8 stored, overflow=1, overflow_cnt=2. Then m_ready=1 -> first 8 items out in order; m_pc stable throughout the stall.
- FIFO full with m_ready=1 and a kept item in the same cycle -> push accepted, no overflow, occupancy stays 8.
- cmd_stop with 3 items buffered and m_ready toggling 1010 -> no further capture; busy stays 1 until the 3rd pop, then IDLE.
- cmd_start and cmd_stop asserted together in IDLE -> remains IDLE; rst_n=0 during DRAIN -> m_valid=0, counters 0 next cycle.
- cfg_filter_bypass=1 with 5 valid items, all drop_instr=1 -> 5 items out, dropped_cnt=0; with TRACE_TIMESTAMP_EN, m_timestamp values strictly increasing and matching capture cycles.
